mem_wb_writeback: RTL and testbench
===================================

// Module: mem_wb_writeback
// PURPOSE
//  MEM/WB pipeline register plus write-back datapath of the RV32I core; sits directly upstream of the register file.
//  Latches MEM-stage results, aligns/extends load data, selects the write-back source, drives the regfile write port.
//  Also exports a forwarding tap and a 64-bit retired-instruction counter (instret).
// PARAMETERS
//  XLEN    32  datapath width
//  CNT_W   64  retired-instruction counter width
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      reset, synchronous, active-high
//  stall          in   1      hold stage register contents
//  flush          in   1      squash: load a bubble into the stage
//  in_valid       in   1      MEM-stage slot holds a real instruction
//  in_reg_write   in   1      instruction writes rd
//  in_rd          in   5      destination register index
//  in_wb_sel      in   2      00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
//  in_funct3      in   3      load width/sign code
//  in_alu_result  in   XLEN   ALU result; bits [1:0] = load byte offset
//  in_mem_rdata   in   XLEN   raw aligned word from data memory
//  in_pc_plus4    in   XLEN   link value for JAL/JALR
//  in_imm         in   XLEN   U-type immediate
//  reg_write      out  1      regfile write enable
//  write_reg      out  5      regfile write index
//  write_data     out  XLEN   regfile write data
//  wb_valid       out  1      stage holds a valid instruction (retiring this cycle)
//  fwd_en         out  1      forwarding tap valid (== reg_write)
//  instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Stage register: valid_q, reg_write_q, rd_q, wb_sel_q, funct3_q, alu_q, rdata_q, pc4_q, imm_q.
//  - Update priority per posedge: rst > flush > stall > capture.
//    rst: every field 0, instret 0. flush: valid_q=0, reg_write_q=0, other fields don't-care.
//    stall (no flush): all fields hold. Otherwise capture all in_* fields.
//  - Latency: in_* captured at edge N appear on write port during cycle N..N+1 (1 cycle).
//  - Outputs combinational from stage register only; no in_* -> out path.
//  - reg_write = valid_q & reg_write_q & (rd_q != 0); x0 writes always suppressed.
//  - write_reg = rd_q. write_data per wb_sel_q: ALU alu_q; PC+4 pc4_q; IMM imm_q; LOAD aligned value.
//  - Load align, off = alu_q[1:0]:
//    000 LB : byte at rdata_q[8*off+:8], sign-extend.  100 LBU: same, zero-extend.
//    001 LH : half at rdata_q[16*off[1]+:16], sign-ext; off[0] ignored.  101 LHU: same, zero-ext.
//    010 LW and reserved 011/110/111: rdata_q unmodified; off ignored.
//  - wb_valid = valid_q. fwd_en = reg_write; forwarding consumers use write_reg/write_data.
//  - During stall, reg_write stays asserted if held instruction writes; duplicate write of
//    the same value to the same register is harmless and required (no one-shot suppression).
//  - instret: +1 on each posedge where valid_q & !stall & !rst; wraps 2^CNT_W-1 -> 0.
//    Counts each instruction once even if held several cycles by stall.
//  - Reset mid-stall or mid-flush: rst wins; next cycle reg_write=0, wb_valid=0, instret=0.
//  - Reset values: reg_write 0, write_reg 0, write_data 0 (ALU select, alu_q=0), wb_valid 0,
//    fwd_en 0, instret 0.
// STRUCTURE
//  - Shared package: WB_ALU/WB_LOAD/WB_PC4/WB_IMM encodings; F3_LB/LH/LW/LBU/LHU codes.
//  - One sub-module: load_align (combinational: rdata, offset, funct3 -> XLEN result).
//  - Stage register, write-back mux and instret counter live in this module.
// TESTING
//  - Reset: rst=1 two cycles with in_valid=1 -> reg_write=0, wb_valid=0, write_data=0, instret=0.
//  - ALU writeback: rd=5, sel ALU, alu=0x1234_5678 -> next cycle reg_write=1, write_reg=5, data=0x12345678.
//  - Loads, rdata=0x8A7B_F0C1: LB off=3 -> 0xFFFFFF8A; LBU off=0 -> 0x000000C1;
//    LH off=2 -> 0xFFFF8A7B; LHU off=0 -> 0x0000F0C1; LW off=1 -> 0x8A7BF0C1.
//  - x0 write: rd=0, reg_write=1, sel PC+4 -> reg_write=0, wb_valid=1, instret +1.
//  - Stall/flush: valid instr, stall=1 3 cycles -> outputs held, instret +1 only on release;
//    stall=1 & flush=1 same edge -> bubble (wb_valid=0, reg_write=0).
//  - Wrap: force instret=2^64-1, retire one -> instret=0.

Source files
------------

// File: rtl/mem_wb_writeback_pkg.sv
// mem_wb_writeback_pkg: write-back source select and load funct3 encodings
package mem_wb_writeback_pkg;
   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_IMM  = 2'b11
   } wb_sel_e;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// mem_wb_writeback_load_align: picks byte/half out of a memory word and extends it
module mem_wb_writeback_load_align
   import mem_wb_writeback_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   always_comb begin
      byte_v = rdata[{off, 3'b000} +: 8];
      half_v = rdata[{off[1], 4'b0000} +: 16];
      result = funct3 == F3_LB  ? {{(XLEN-8){byte_v[7]}}, byte_v} :
               funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, byte_v} :
               funct3 == F3_LH  ? {{(XLEN-16){half_v[15]}}, half_v} :
               funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, half_v} : rdata;
   end
endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB stage register, write-back mux, forwarding tap and instret counter
module mem_wb_writeback
   import mem_wb_writeback_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_reg_write,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_wb_sel,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [XLEN-1:0]  in_mem_rdata,
   input  logic [XLEN-1:0]  in_pc_plus4,
   input  logic [XLEN-1:0]  in_imm,
   output logic             reg_write,
   output logic [4:0]       write_reg,
   output logic [XLEN-1:0]  write_data,
   output logic             wb_valid,
   output logic             fwd_en,
   output logic [CNT_W-1:0] instret
);
   logic             valid_q, valid_d, reg_write_q, reg_write_d;
   logic [4:0]       rd_q, rd_d;
   wb_sel_e          wb_sel_q, wb_sel_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [XLEN-1:0]  alu_q, alu_d, rdata_q, rdata_d, pc4_q, pc4_d, imm_q, imm_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [XLEN-1:0]  load_data;
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      rd_d        = rd_q;
      wb_sel_d    = wb_sel_q;
      funct3_d    = funct3_q;
      alu_d       = alu_q;
      rdata_d     = rdata_q;
      pc4_d       = pc4_q;
      imm_d       = imm_q;
      instret_d   = instret_q;
      if (rst) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         rd_d        = '0;
         wb_sel_d    = WB_ALU;
         funct3_d    = '0;
         alu_d       = '0;
         rdata_d     = '0;
         pc4_d       = '0;
         imm_d       = '0;
         instret_d   = '0;
      end else begin
         // a stalled instruction retires only on the edge that releases it
         if (valid_q && !stall) instret_d = instret_q + 1'b1;
         if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
         end else if (!stall) begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write;
            rd_d        = in_rd;
            wb_sel_d    = wb_sel_e'(in_wb_sel);
            funct3_d    = in_funct3;
            alu_d       = in_alu_result;
            rdata_d     = in_mem_rdata;
            pc4_d       = in_pc_plus4;
            imm_d       = in_imm;
         end
      end
   end
   always_ff @(posedge clk) begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_sel_q    <= wb_sel_d;
      funct3_q    <= funct3_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
      instret_q   <= instret_d;
   end
   mem_wb_writeback_load_align #(.XLEN(XLEN)) u_align (
      .rdata  (rdata_q),
      .off    (alu_q[1:0]),
      .funct3 (funct3_q),
      .result (load_data)
   );
   always_comb begin
      reg_write  = valid_q && reg_write_q && (rd_q != 5'd0);
      write_reg  = rd_q;
      write_data = wb_sel_q == WB_LOAD ? load_data :
                   wb_sel_q == WB_PC4  ? pc4_q :
                   wb_sel_q == WB_IMM  ? imm_q : alu_q;
      wb_valid   = valid_q;
      fwd_en     = reg_write;
      instret    = instret_q;
   end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed and randomized checks against a behavioural write-back model
module tb_mem_wb_writeback;
   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
   logic        reg_write, wb_valid, fwd_en;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [63:0] instret;
   int n_cmp = 0;
   int n_err = 0;
   logic        m_valid, m_rw;
   logic [4:0]  m_rd;
   logic [1:0]  m_sel;
   logic [2:0]  m_f3;
   logic [31:0] m_alu, m_rdata, m_pc4, m_imm;
   logic [63:0] m_cnt;

   always #5 clk = ~clk;

   mem_wb_writeback dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
      .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .wb_valid(wb_valid), .fwd_en(fwd_en), .instret(instret)
   );

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] off);
      logic [31:0] v;
      int          sh;
      case (f3)
         3'b000, 3'b100: begin
            sh = 8 * int'(off);
            v  = (w >> sh) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
         end
         3'b001, 3'b101: begin
            sh = off >= 2'd2 ? 16 : 0;
            v  = (w >> sh) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] exp_wdata();
      case (m_sel)
         2'd0: return m_alu;
         2'd1: return exp_load(m_f3, m_rdata, m_alu[1:0]);
         2'd2: return m_pc4;
         default: return m_imm;
      endcase
   endfunction

   task automatic set_in(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] imm);
      in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
      in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc4; in_imm = imm;
   endtask

   // advance one clock; model follows the stage rules, outputs are then sampled at negedge
   task automatic step();
      if (rst) begin
         {m_valid, m_rw, m_rd, m_sel, m_f3} = '0;
         {m_alu, m_rdata, m_pc4, m_imm} = '0;
         m_cnt = 0;
      end else begin
         if (m_valid && !stall) m_cnt = m_cnt + 64'd1;
         if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0;
         end else if (!stall) begin
            m_valid = in_valid; m_rw = in_reg_write; m_rd = in_rd; m_sel = in_wb_sel; m_f3 = in_funct3;
            m_alu = in_alu_result; m_rdata = in_mem_rdata; m_pc4 = in_pc_plus4; m_imm = in_imm;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      set_in(1'b1, 1'b1, 5'd3, 2'd2, 3'd0, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3);
      step();
      step();
      n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
      n_cmp++; if (write_data !== 32'h0) begin n_err++; $display("FAIL reset_write_data got %h want 0", write_data); end
      n_cmp++; if (write_reg !== 5'd0) begin n_err++; $display("FAIL reset_write_reg got %0d want 0", write_reg); end
      n_cmp++; if (fwd_en !== 1'b0) begin n_err++; $display("FAIL reset_fwd_en got %b want 0", fwd_en); end
      n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret got %0d want 0", instret); end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      set_in(1'b1, 1'b1, 5'd5, 2'd0, 3'd2, 32'h1234_5678, 32'hFFFF_FFFF, 32'h44, 32'h55);
      step();
      n_cmp++; if (reg_write !== 1'b1) begin n_err++; $display("FAIL alu_reg_write got %b want 1", reg_write); end
      n_cmp++; if (write_reg !== 5'd5) begin n_err++; $display("FAIL alu_write_reg got %0d want 5", write_reg); end
      n_cmp++; if (write_data !== 32'h1234_5678) begin n_err++; $display("FAIL alu_write_data got %h want 12345678", write_data); end
      n_cmp++; if (fwd_en !== 1'b1) begin n_err++; $display("FAIL alu_fwd_en got %b want 1", fwd_en); end
      n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL alu_instret got %0d want 0", instret); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  offs[5] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
      logic [31:0] exps[5] = '{32'hFFFF_FF8A, 32'h0000_00C1, 32'hFFFF_8A7B, 32'h0000_F0C1, 32'h8A7B_F0C1};
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b1, 5'd7, 2'd1, f3s[i], {30'h400, offs[i]}, 32'h8A7B_F0C1, 32'h0, 32'h0);
         step();
         n_cmp++; if (write_data !== exps[i]) begin n_err++; $display("FAIL load_%0d f3=%0d off=%0d got %h want %h", i, f3s[i], offs[i], write_data, exps[i]); end
      end
   endtask

   task automatic test_x0();
      logic [63:0] base;
      set_in(1'b1, 1'b1, 5'd0, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0104, 32'h0);
      step();
      base = m_cnt;
      n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL x0_reg_write got %b want 0", reg_write); end
      n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL x0_wb_valid got %b want 1", wb_valid); end
      in_valid = 1'b0;
      step();
      n_cmp++; if (instret !== base + 64'd1) begin n_err++; $display("FAIL x0_instret got %0d want %0d", instret, base + 64'd1); end
   endtask

   task automatic test_stall();
      logic [63:0] base;
      set_in(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0);
      step();
      base = m_cnt;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
         step();
         n_cmp++; if (write_data !== 32'h0000_CAFE || write_reg !== 5'd9 || reg_write !== 1'b1)
            begin n_err++; $display("FAIL stall_hold_%0d got rw=%b rd=%0d d=%h want 1/9/cafe", i, reg_write, write_reg, write_data); end
         n_cmp++; if (instret !== base) begin n_err++; $display("FAIL stall_instret_%0d got %0d want %0d", i, instret, base); end
      end
      stall = 1'b0;
      in_valid = 1'b0;
      step();
      n_cmp++; if (instret !== base + 64'd1) begin n_err++; $display("FAIL stall_release_instret got %0d want %0d", instret, base + 64'd1); end
      set_in(1'b1, 1'b1, 5'd4, 2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 32'hABC0_0000);
      step();
      base = m_cnt;
      stall = 1'b1; flush = 1'b1;
      step();
      n_cmp++; if (wb_valid !== 1'b0 || reg_write !== 1'b0) begin n_err++; $display("FAIL stall_flush got v=%b rw=%b want 0/0", wb_valid, reg_write); end
      n_cmp++; if (instret !== base) begin n_err++; $display("FAIL stall_flush_instret got %0d want %0d", instret, base); end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 39) == 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         set_in(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
         step();
         n_cmp++; if (reg_write !== (m_valid && m_rw && m_rd != 5'd0) || fwd_en !== reg_write || wb_valid !== m_valid)
            begin n_err++; $display("FAIL rand_ctl_%0d got rw=%b fwd=%b v=%b want v=%b", i, reg_write, fwd_en, wb_valid, m_valid); end
         n_cmp++; if (instret !== m_cnt) begin n_err++; $display("FAIL rand_instret_%0d got %0d want %0d", i, instret, m_cnt); end
         if (m_valid) begin
            n_cmp++; if (write_data !== exp_wdata() || write_reg !== m_rd)
               begin n_err++; $display("FAIL rand_data_%0d got rd=%0d d=%h want rd=%0d d=%h", i, write_reg, write_data, m_rd, exp_wdata()); end
         end
      end
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_wrap();
      set_in(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0, 32'h0);
      step();
      dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL wrap_instret got %h want 0", instret); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_x0();
      test_stall();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
